// File: rtl/seq_mult.sv
// seq_mult: signed/unsigned shift-add multiplier, one multiplier bit per cycle, magnitudes re-signed at the end.
// Latency WIDTH cycles from accepted start to done; start is only sampled in IDLE and is never queued.
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   localparam int                PW        = 2 * WIDTH;
   localparam int                CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [WIDTH-1:0]  ONE_W     = WIDTH'(1);
   localparam logic [PW-1:0]     ONE_P     = PW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   // Operation context captured at acceptance; magnitudes are unsigned WIDTH-bit.
   typedef struct packed {
      logic             neg;
      logic [WIDTH-1:0] mcand;
      logic [WIDTH-1:0] mplier;
   } op_t;

   state_t            state;
   state_t            state_nxt;
   op_t               op;
   op_t               op_load;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     acc_nxt;
   logic [PW-1:0]     p_nxt;
   logic [WIDTH:0]    sum;
   logic [WIDTH-1:0]  addend;
   logic [CW-1:0]     cnt;
   logic              last_step;
   logic              x_neg;
   logic              y_neg;

   always_comb begin
      x_neg          = signed_mode & X[WIDTH-1];
      y_neg          = signed_mode & Y[WIDTH-1];
      op_load.neg    = signed_mode & (X[WIDTH-1] ^ Y[WIDTH-1]);
      op_load.mcand  = x_neg ? (~X + ONE_W) : X;
      op_load.mplier = y_neg ? (~Y + ONE_W) : Y;
   end

   // One step: add into the upper W+1 bits, then shift the whole accumulator right.
   always_comb begin
      addend    = op.mplier[0] ? op.mcand : '0;
      sum       = {1'b0, acc[PW-1:WIDTH]} + {1'b0, addend};
      acc_nxt   = PW'({sum, acc[WIDTH-1:0]} >> 1);
      p_nxt     = op.neg ? (~acc_nxt + ONE_P) : acc_nxt;
      last_step = (cnt == LAST_STEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CALC:    busy = 1'b1;
         DONE:    begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op  <= '0;
         acc <= '0;
         cnt <= '0;
         P   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op  <= op_load;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            CALC: begin
               acc       <= acc_nxt;
               op.mplier <= op.mplier >> 1;
               cnt       <= cnt + CNT_ONE;
               // The final step's result goes straight to P on the CALC->DONE edge.
               if (last_step) begin
                  P <= p_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: four widths (4, 8, 12, 16) checked every cycle against an arithmetic reference,
// plus hand-computed products, latency, handshake spacing and reset behaviour.
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  start_v = '0;
   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic        sm_r = 1'b0;
   logic [15:0] x_r = '0;
   logic [15:0] y_r = '0;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [23:0] p12;
   logic [31:0] p16;
   logic [31:0] p_all [4];

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   int          busy_cnt = 0;
   int          done_cnt = 0;

   // Reference: cycles since acceptance (-1 = idle), pending and visible products.
   int          m_cnt [4] = '{-1, -1, -1, -1};
   logic [31:0] m_exp [4];
   logic [31:0] m_p   [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_r),
      .X(x_r[3:0]), .Y(y_r[3:0]), .busy(busy_v[0]), .done(done_v[0]), .P(p4));
   seq_mult #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_r),
      .X(x_r[7:0]), .Y(y_r[7:0]), .busy(busy_v[1]), .done(done_v[1]), .P(p8));
   seq_mult #(.WIDTH(12)) u_w12 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_r),
      .X(x_r[11:0]), .Y(y_r[11:0]), .busy(busy_v[2]), .done(done_v[2]), .P(p12));
   seq_mult #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .signed_mode(sm_r),
      .X(x_r), .Y(y_r), .busy(busy_v[3]), .done(done_v[3]), .P(p16));

   assign p_all[0] = {24'd0, p4};
   assign p_all[1] = {16'd0, p8};
   assign p_all[2] = {8'd0, p12};
   assign p_all[3] = p16;

   function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                           input logic [15:0] x, input logic [15:0] y);
      longint xv, yv, pr;
      xv = longint'(x) & ((longint'(1) << w) - 1);
      yv = longint'(y) & ((longint'(1) << w) - 1);
      if (sm && x[w-1]) xv = xv - (longint'(1) << w);
      if (sm && y[w-1]) yv = yv - (longint'(1) << w);
      pr = xv * yv;
      return 32'(pr & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 4; i++) begin
         if (!rst_n) begin
            m_cnt[i] = -1;
            m_p[i]   = 32'd0;
         end else if (m_cnt[i] < 0) begin
            if (start_v[i]) begin
               m_cnt[i] = 0;
               m_exp[i] = ref_mul(4 * (i + 1), sm_r, x_r, y_r);
            end
         end else begin
            m_cnt[i]++;
            if (m_cnt[i] == 4 * (i + 1)) m_p[i] = m_exp[i];
            else if (m_cnt[i] > 4 * (i + 1)) m_cnt[i] = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (busy_v[1]) busy_cnt++;
      if (done_v[1]) done_cnt++;
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy w%0d", 4 * (i + 1)), 32'(busy_v[i]), (m_cnt[i] >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("done w%0d", 4 * (i + 1)), 32'(done_v[i]),
                (m_cnt[i] == 4 * (i + 1)) ? 32'd1 : 32'd0);
            chk($sformatf("P w%0d", 4 * (i + 1)), p_all[i], m_p[i]);
         end
      end
   end

   task automatic wait_done(input int i, output logic [31:0] p, output int lat);
      lat = 0;
      while (done_v[i] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("done reached w%0d", 4 * (i + 1)), 32'(done_v[i]), 32'd1);
      p = p_all[i];
      @(negedge clk);
   endtask

   task automatic run_op(input int i, input logic sm, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output int lat);
      @(negedge clk);
      sm_r       = sm;
      x_r        = x;
      y_r        = y;
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      wait_done(i, p, lat);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [15:0] sx [5] = '{16'h00FF, 16'h0080, 16'h0080, 16'h00FB, 16'h0007};
   logic [15:0] sy [5] = '{16'h0001, 16'h0080, 16'h007F, 16'h0000, 16'h00FD};
   logic [31:0] sp [5] = '{32'hFFFF, 32'h4000, 32'hC080, 32'h0000, 32'hFFEB};

   initial begin
      logic [31:0] p;
      int          lat;
      int          n;
      int          dts [$];
      logic        rs;
      logic [15:0] rx, ry;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset busy", 32'(busy_v), 32'd0);
      chk("reset done", 32'(done_v), 32'd0);
      chk("reset P w8", p_all[1], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned extremes, latency and busy length at W=8
      busy_cnt = 0;
      run_op(1, 1'b0, 16'h00FF, 16'h00FF, p, lat);
      chk("255x255", p, 32'h0000FE01);
      chk("latency w8", 32'(lat), 32'd8);
      repeat (3) @(negedge clk);
      chk("busy cycles w8", 32'(busy_cnt), 32'd9);
      run_op(1, 1'b0, 16'h0000, 16'h0037, p, lat);
      chk("0x37", p, 32'h0);

      for (int k = 0; k < 5; k++) begin
         run_op(1, 1'b1, sx[k], sy[k], p, lat);
         chk($sformatf("signed vec %0d", k), p, sp[k]);
      end

      run_op(0, 1'b1, 16'h0008, 16'h0008, p, lat);
      chk("w4 -8x-8", p, 32'h40);
      run_op(0, 1'b1, 16'h0008, 16'h0007, p, lat);
      chk("w4 -8x7", p, 32'hC8);
      run_op(2, 1'b0, 16'h0FFF, 16'h0FFF, p, lat);
      chk("w12 fffxfff", p, 32'h00FFE001);
      run_op(3, 1'b0, 16'hFFFF, 16'hFFFF, p, lat);
      chk("w16 ffffxffff", p, 32'hFFFE0001);
      run_op(1, 1'b1, 16'h0007, 16'h00FD, p, lat);

      // Reset in the middle of 13x11: outputs clear at once, no late done
      @(negedge clk);
      sm_r = 1'b0; x_r = 16'd13; y_r = 16'd11; start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset busy", 32'(busy_v[1]), 32'd0);
      chk("mid reset done", 32'(done_v[1]), 32'd0);
      chk("mid reset P", p_all[1], 32'd0);
      done_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("no done after reset", 32'(done_cnt), 32'd0);

      // Start accepted on the first edge after release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; sm_r = 1'b0; x_r = 16'd3; y_r = 16'd5; start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      chk("accept after release", 32'(busy_v[1]), 32'd1);
      wait_done(1, p, lat);
      chk("3x5", p, 32'd15);
      chk("latency after release", 32'(lat), 32'd8);

      // start held high with operands changing every cycle
      @(negedge clk);
      start_v[1] = 1'b1;
      n = 0;
      repeat (46) begin
         x_r = 16'($urandom);
         y_r = 16'($urandom);
         sm_r = 1'($urandom);
         @(negedge clk);
         n++;
         if (done_v[1]) dts.push_back(n);
      end
      start_v[1] = 1'b0;
      repeat (12) @(negedge clk);
      chk("held-start done count", 32'(dts.size()), 32'd4);
      if (dts.size() == 4) begin
         chk("held-start first done", 32'(dts[0]), 32'd9);
         for (int k = 1; k < 4; k++)
            chk($sformatf("held-start gap %0d", k), 32'(dts[k] - dts[k-1]), 32'd10);
      end

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               run_op(0, 1'(s), 16'(a), 16'(b), p, lat);
               chk("w4 exhaustive", p, ref_mul(4, 1'(s), 16'(a), 16'(b)));
            end

      for (int k = 0; k < 1000; k++) begin
         rs = 1'($urandom); rx = 16'($urandom); ry = 16'($urandom);
         run_op(1, rs, rx, ry, p, lat);
         chk("w8 random", p, ref_mul(8, rs, rx, ry));
      end
      for (int k = 0; k < 1000; k++) begin
         rs = 1'($urandom); rx = 16'($urandom); ry = 16'($urandom);
         run_op(2, rs, rx, ry, p, lat);
         chk("w12 random", p, ref_mul(12, rs, rx, ry));
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier with selectable signed/unsigned mode and a start/done handshake. It generalises the team's combinational 4x4 array multiplier to any operand width. It trades the adder array for a single W-bit adder iterated over W cycles. It sits beside the ALU datapath, and a controller issues one multiplication at a time.

## Interface
- WIDTH, default 8: operand width in bits, minimum 2; product width is 2*WIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- X  input  WIDTH  multiplicand; sampled with start.
- Y  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse, high in DONE.
- P  output  2*WIDTH  product register; holds the last result until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on a rising edge with start=1.
  - The multiplicand magnitude is latched: |X| if signed_mode and X[MSB]=1, else X.
  - The multiplier magnitude is latched: |Y| if signed_mode and Y[MSB]=1, else Y.
  - neg = signed_mode & (X[MSB] ^ Y[MSB]) is latched.
  - The accumulator clears and the step counter is set to 0.
- Magnitudes are held as WIDTH-bit unsigned values, so |-2^(W-1)| = 2^(W-1) is representable.
- CALC performs one step per cycle, LSB-first:
  - If the current multiplier bit = 1, add the multiplicand into the upper W+1 bits of the accumulator.
  - Shift the accumulator right by 1.
  - Increment the counter.
- After exactly WIDTH steps, CALC -> DONE. On that same edge, P loads the accumulator, or its two's-complement negation (mod 2^(2W)) if neg=1.
- DONE -> IDLE unconditionally on the next edge.
- start is ignored in CALC and DONE. It is not queued.
- X, Y and signed_mode may change freely after being sampled; they do not affect the running operation.
- Result widths:
  - Unsigned: full 2W-bit product, never overflows (max (2^W-1)^2).
  - Signed: full 2W-bit two's-complement product. (-2^(W-1))^2 = 2^(2W-2) fits as positive.
  - A zero product with neg=1 yields 0, since negating 0 gives 0.
- Reset (rst_n=0, at any time including mid-CALC):
  - state=IDLE, P=0, busy=0, done=0, counter and accumulator cleared.
  - The in-flight operation is discarded and no done is produced.
  - The first start is accepted on the first rising edge with rst_n=1.

## Timing
- Let edge t0 be the rising edge where start=1 is sampled in IDLE.
- busy rises after t0 and stays high through t0+WIDTH+1.
- CALC occupies edges t0+1 .. t0+WIDTH, one step per edge.
- P is updated and done rises at edge t0+WIDTH. done falls at t0+WIDTH+1.
- Latency is WIDTH cycles from start sample to done.
- Earliest next accepted start is at edge t0+WIDTH+2, giving a throughput of one product per WIDTH+2 cycles.
- P changes only at the DONE transition or on reset. It is stable whenever done=1 and remains stable afterwards.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 during CALC of 13x11 (W=8) -> busy=0, done=0, P=0 immediately. No done pulse follows after release.
- Unsigned extremes, W=8: 255x255 -> P=0xFE01. 0x37 -> P=0x0000. done pulses exactly 8 cycles after the start edge; busy is high for 9 cycles.
- Signed, W=8: -1x1 -> 0xFFFF. -128x-128 -> 0x4000. -128x127 -> 0xC080. -5x0 -> 0x0000. 7x-3 -> 0xFFEB.
- Handshake: hold start=1 continuously and toggle X/Y during CALC -> each result matches the operands captured at acceptance. Accepted starts are spaced by 10 cycles (W=8).
- Parametrisation: W=4, exhaustive 256 unsigned and 256 signed pairs -> P equals the reference product X*Y in 8 bits. W=16 spot check 0xFFFFx0xFFFF -> 0xFFFE0001.
- Random: 1000 random operands and modes at W=8 and W=12, compared against a behavioural model. P must hold its value between done pulses.
